// File: rtl/tb_exit_pkg.sv
// Shared types for the end-of-test monitor: verdict codes, FSM states and
// per-channel event classes.
package tb_exit_pkg;

  localparam int unsigned EXIT_W = 32;

  typedef enum logic [2:0] {
    RES_NONE      = 3'd0,
    RES_PASS      = 3'd1,
    RES_FAIL      = 3'd2,
    RES_EXIT_FAIL = 3'd3,
    RES_TIMEOUT   = 3'd4
  } result_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE      = 2'd0,
    CLS_PASS      = 2'd1,
    CLS_FAIL      = 2'd2,
    CLS_EXIT_FAIL = 2'd3
  } ch_class_e;

  function automatic logic is_fail(input logic [1:0] cls);
    return (cls == CLS_FAIL) || (cls == CLS_EXIT_FAIL);
  endfunction

endpackage

// File: rtl/tb_exit_ch_tracker.sv
// One monitored channel: classifies the strobes seen this cycle and latches
// the first event so later strobes on the same channel are ignored.
module tb_exit_ch_tracker
  import tb_exit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              capture_i,
  input  logic              passed_i,
  input  logic              failed_i,
  input  logic              exit_valid_i,
  input  logic [EXIT_W-1:0] exit_value_i,
  output logic              evt_c,
  output logic [1:0]        evt_class_c,
  output logic              done_o,
  output logic [1:0]        class_o
);

  // Priority: failed > nonzero exit > zero exit > passed
  always_comb begin
    evt_class_c = CLS_NONE;
    if (failed_i)                                 evt_class_c = CLS_FAIL;
    else if (exit_valid_i && (exit_value_i != '0)) evt_class_c = CLS_EXIT_FAIL;
    else if (exit_valid_i || passed_i)            evt_class_c = CLS_PASS;
  end

  assign evt_c = capture_i && !done_o && (evt_class_c != CLS_NONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_o  <= 1'b0;
      class_o <= CLS_NONE;
    end else if (evt_c) begin
      done_o  <= 1'b1;
      class_o <= evt_class_c;
    end
  end

endmodule

// File: rtl/tb_exit_monitor.sv
// Multi-channel end-of-test monitor: merges per-channel events, a cycle limit
// and a heartbeat into one sticky registered verdict.
module tb_exit_monitor
  import tb_exit_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned HEARTBEAT = 10000,
  parameter int unsigned WAIT_ALL  = 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       enable_i,
  input  logic [CNT_W-1:0]                           max_cycles_i,
  input  logic [NUM_CH-1:0]                          ch_passed_i,
  input  logic [NUM_CH-1:0]                          ch_failed_i,
  input  logic [NUM_CH-1:0]                          ch_exit_valid_i,
  input  logic [NUM_CH*32-1:0]                       ch_exit_value_i,
  output logic                                       done_o,
  output logic [2:0]                                 result_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch_o,
  output logic [31:0]                                exit_value_o,
  output logic [NUM_CH-1:0]                          ch_done_o,
  output logic [CNT_W-1:0]                           cycle_cnt_o,
  output logic                                       tick_o
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e            state_q, state_d;
  logic              counting;
  logic [NUM_CH-1:0] evt, fail_evt, eff_pass;
  logic [1:0]        evt_cls [NUM_CH];
  logic [1:0]        cls_q   [NUM_CH];
  logic [CNT_W:0]    cnt_inc;

  logic              fail_found, pass_found, fail_exit;
  logic [CH_W-1:0]   fail_idx, pass_idx;
  logic [EXIT_W-1:0] fail_val;
  logic              verdict;
  result_e           v_res;
  logic [CH_W-1:0]   v_ch;
  logic [EXIT_W-1:0] v_val;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tb_exit_ch_tracker u_trk (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .capture_i    (counting),
      .passed_i     (ch_passed_i[g]),
      .failed_i     (ch_failed_i[g]),
      .exit_valid_i (ch_exit_valid_i[g]),
      .exit_value_i (ch_exit_value_i[g*EXIT_W +: EXIT_W]),
      .evt_c        (evt[g]),
      .evt_class_c  (evt_cls[g]),
      .done_o       (ch_done_o[g]),
      .class_o      (cls_q[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_RUN;
      ST_RUN:  if (verdict)  state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    counting = (state_q == ST_RUN) && enable_i;
  end

  assign cnt_inc = {1'b0, cycle_cnt_o} + (CNT_W+1)'(1);

  // Lowest-index encoders; failures are searched first so they outrank passes
  always_comb begin
    fail_found = 1'b0;
    pass_found = 1'b0;
    fail_exit  = 1'b0;
    fail_idx   = '0;
    pass_idx   = '0;
    fail_val   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fail_evt[i] = evt[i] && is_fail(evt_cls[i]);
      eff_pass[i] = (ch_done_o[i] && (cls_q[i] == CLS_PASS)) ||
                    (evt[i] && (evt_cls[i] == CLS_PASS));
      if (fail_evt[i] && !fail_found) begin
        fail_found = 1'b1;
        fail_idx   = CH_W'(i);
        fail_exit  = (evt_cls[i] == CLS_EXIT_FAIL);
        fail_val   = fail_exit ? ch_exit_value_i[i*EXIT_W +: EXIT_W] : '0;
      end
      if (evt[i] && !pass_found) begin
        pass_found = 1'b1;
        pass_idx   = CH_W'(i);
      end
    end
  end

  // Channel verdicts take precedence over the cycle limit
  always_comb begin
    verdict = 1'b0;
    v_res   = RES_NONE;
    v_ch    = '0;
    v_val   = '0;
    if (counting) begin
      if (fail_found) begin
        verdict = 1'b1;
        v_res   = fail_exit ? RES_EXIT_FAIL : RES_FAIL;
        v_ch    = fail_idx;
        v_val   = fail_val;
      end else if (pass_found && ((WAIT_ALL == 0) || (&eff_pass))) begin
        verdict = 1'b1;
        v_res   = RES_PASS;
        v_ch    = pass_idx;
      end else if ((max_cycles_i != '0) && (cnt_inc >= {1'b0, max_cycles_i})) begin
        verdict = 1'b1;
        v_res   = RES_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_o       <= 1'b0;
      result_o     <= RES_NONE;
      fail_ch_o    <= '0;
      exit_value_o <= '0;
      cycle_cnt_o  <= '0;
    end else begin
      if (counting && !cnt_inc[CNT_W]) cycle_cnt_o <= cnt_inc[CNT_W-1:0];
      if (verdict) begin
        done_o       <= 1'b1;
        result_o     <= v_res;
        fail_ch_o    <= v_ch;
        exit_value_o <= v_val;
      end
    end
  end

  if (HEARTBEAT > 0) begin : g_hb
    localparam int unsigned HB_W = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
    logic [HB_W-1:0] hb_q;
    logic            hb_wrap;

    assign hb_wrap = (hb_q == HB_W'(HEARTBEAT - 1));

    // Suppressed on the verdict cycle so the pulse never shows up in DONE
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hb_q   <= '0;
        tick_o <= 1'b0;
      end else begin
        tick_o <= counting && hb_wrap && !verdict;
        if (counting) hb_q <= hb_wrap ? '0 : hb_q + HB_W'(1);
      end
    end
  end else begin : g_no_hb
    assign tick_o = 1'b0;
  end

endmodule

// File: tb/tb_tb_exit_monitor.sv
// Directed bench for tb_exit_monitor: a wait-all instance (heartbeat 4) and a
// first-event instance (8-bit counter) share the channel strobes.
module tb_tb_exit_monitor;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [31:0]  max_a;
  logic [7:0]   max_b;
  logic [3:0]   passed, failed, exit_valid;
  logic [127:0] exit_value;

  logic         done_a, done_b, tick_a, tick_b;
  logic [2:0]   result_a, result_b;
  logic [1:0]   fail_ch_a, fail_ch_b;
  logic [31:0]  exitval_a, exitval_b, cnt_a;
  logic [7:0]   cnt_b;
  logic [3:0]   ch_done_a, ch_done_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tb_exit_monitor #(.NUM_CH(4), .CNT_W(32), .HEARTBEAT(4), .WAIT_ALL(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .max_cycles_i(max_a),
    .ch_passed_i(passed), .ch_failed_i(failed), .ch_exit_valid_i(exit_valid),
    .ch_exit_value_i(exit_value), .done_o(done_a), .result_o(result_a),
    .fail_ch_o(fail_ch_a), .exit_value_o(exitval_a), .ch_done_o(ch_done_a),
    .cycle_cnt_o(cnt_a), .tick_o(tick_a)
  );

  tb_exit_monitor #(.NUM_CH(4), .CNT_W(8), .HEARTBEAT(0), .WAIT_ALL(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .max_cycles_i(max_b),
    .ch_passed_i(passed), .ch_failed_i(failed), .ch_exit_valid_i(exit_valid),
    .ch_exit_value_i(exit_value), .done_o(done_b), .result_o(result_b),
    .fail_ch_o(fail_ch_b), .exit_value_o(exitval_b), .ch_done_o(ch_done_b),
    .cycle_cnt_o(cnt_b), .tick_o(tick_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    passed = '0; failed = '0; exit_valid = '0; exit_value = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; max_a = '0; max_b = '0;
    clear_strobes();
    step(2);
    rst = 1'b0;
  endtask

  // IDLE -> RUN; the transition cycle itself is not counted
  task automatic start_run();
    en = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; max_a = '0; max_b = '0;
    clear_strobes();
    failed = 4'hF;
    step(2);
    rst = 1'b0; failed = '0;
    step(1);
    n_tests++; if (done_a !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_tests++; if (result_a !== 3'd0)   begin n_fail++; $display("FAIL reset_result: got %0d want 0", result_a); end
    n_tests++; if (fail_ch_a !== 2'd0)  begin n_fail++; $display("FAIL reset_fail_ch: got %0d want 0", fail_ch_a); end
    n_tests++; if (exitval_a !== 32'd0) begin n_fail++; $display("FAIL reset_exit_value: got %h want 0", exitval_a); end
    n_tests++; if (ch_done_a !== 4'h0)  begin n_fail++; $display("FAIL reset_ch_done: got %b want 0000", ch_done_a); end
    n_tests++; if (cnt_a !== 32'd0)     begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
    n_tests++; if (tick_a !== 1'b0)     begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick_a); end
    n_tests++; if (done_b !== 1'b0)     begin n_fail++; $display("FAIL reset_done_b: got %b want 0", done_b); end
  endtask

  task automatic test_wait_all_pass();
    do_reset();
    start_run();
    for (int c = 1; c <= 40; c++) begin
      passed = (c % 10 == 0) ? 4'(1 << (c / 10 - 1)) : 4'h0;
      if (c == 40) begin
        n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL wa_pass_early: got %b want 0", done_a); end
      end
      step(1);
    end
    passed = '0;
    n_tests++; if (done_a !== 1'b1)    begin n_fail++; $display("FAIL wa_pass_done: got %b want 1", done_a); end
    n_tests++; if (result_a !== 3'd1)  begin n_fail++; $display("FAIL wa_pass_result: got %0d want 1", result_a); end
    n_tests++; if (ch_done_a !== 4'hF) begin n_fail++; $display("FAIL wa_pass_ch_done: got %b want 1111", ch_done_a); end
    n_tests++; if (cnt_a !== 32'd40)   begin n_fail++; $display("FAIL wa_pass_cnt: got %0d want 40", cnt_a); end
  endtask

  task automatic test_wait_all_exit();
    do_reset();
    start_run();
    for (int c = 1; c <= 12; c++) begin
      passed = (c == 5) ? 4'b0001 : 4'b0000;
      exit_valid = (c == 12) ? 4'b0100 : 4'b0000;
      exit_value[2*32 +: 32] = 32'h2A;
      if (c == 12) begin
        n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL wa_exit_early: got %b want 0", done_a); end
      end
      step(1);
    end
    clear_strobes();
    n_tests++; if (result_a !== 3'd3)   begin n_fail++; $display("FAIL wa_exit_result: got %0d want 3", result_a); end
    n_tests++; if (fail_ch_a !== 2'd2)  begin n_fail++; $display("FAIL wa_exit_fail_ch: got %0d want 2", fail_ch_a); end
    n_tests++; if (exitval_a !== 32'h2A) begin n_fail++; $display("FAIL wa_exit_value: got %h want 2a", exitval_a); end
    n_tests++; if (ch_done_a !== 4'b0101) begin n_fail++; $display("FAIL wa_exit_ch_done: got %b want 0101", ch_done_a); end
    passed = 4'b0010;
    step(1);
    passed = '0;
    n_tests++; if (ch_done_a !== 4'b0101) begin n_fail++; $display("FAIL wa_exit_frozen: got %b want 0101", ch_done_a); end
    n_tests++; if (result_a !== 3'd3)   begin n_fail++; $display("FAIL wa_exit_sticky: got %0d want 3", result_a); end
  endtask

  task automatic test_first_event();
    do_reset();
    start_run();
    step(1);
    failed = 4'b1000; exit_valid = 4'b0010;
    step(1);
    clear_strobes();
    n_tests++; if (done_b !== 1'b1)      begin n_fail++; $display("FAIL fe_mix_done: got %b want 1", done_b); end
    n_tests++; if (result_b !== 3'd2)    begin n_fail++; $display("FAIL fe_mix_result: got %0d want 2", result_b); end
    n_tests++; if (fail_ch_b !== 2'd3)   begin n_fail++; $display("FAIL fe_mix_fail_ch: got %0d want 3", fail_ch_b); end
    n_tests++; if (ch_done_b !== 4'b1010) begin n_fail++; $display("FAIL fe_mix_ch_done: got %b want 1010", ch_done_b); end
    do_reset();
    start_run();
    failed = 4'b1010;
    step(1);
    clear_strobes();
    n_tests++; if (result_b !== 3'd2)  begin n_fail++; $display("FAIL fe_two_fail_result: got %0d want 2", result_b); end
    n_tests++; if (fail_ch_b !== 2'd1) begin n_fail++; $display("FAIL fe_two_fail_ch: got %0d want 1", fail_ch_b); end
    do_reset();
    start_run();
    passed = 4'b0100;
    step(1);
    clear_strobes();
    n_tests++; if (result_b !== 3'd1)  begin n_fail++; $display("FAIL fe_pass_result: got %0d want 1", result_b); end
    n_tests++; if (fail_ch_b !== 2'd2) begin n_fail++; $display("FAIL fe_pass_fail_ch: got %0d want 2", fail_ch_b); end
  endtask

  task automatic test_timeout();
    do_reset();
    max_a = 32'd100;
    start_run();
    step(99);
    n_tests++; if (done_a !== 1'b0)   begin n_fail++; $display("FAIL to_early: got %b want 0", done_a); end
    n_tests++; if (cnt_a !== 32'd99)  begin n_fail++; $display("FAIL to_cnt99: got %0d want 99", cnt_a); end
    step(1);
    n_tests++; if (result_a !== 3'd4) begin n_fail++; $display("FAIL to_result: got %0d want 4", result_a); end
    n_tests++; if (cnt_a !== 32'd100) begin n_fail++; $display("FAIL to_cnt: got %0d want 100", cnt_a); end
    n_tests++; if (fail_ch_a !== 2'd0) begin n_fail++; $display("FAIL to_fail_ch: got %0d want 0", fail_ch_a); end
    n_tests++; if (tick_a !== 1'b0)   begin n_fail++; $display("FAIL to_tick_in_done: got %b want 0", tick_a); end
    step(3);
    n_tests++; if (cnt_a !== 32'd100) begin n_fail++; $display("FAIL to_cnt_frozen: got %0d want 100", cnt_a); end
    do_reset();
    max_a = 32'd100;
    start_run();
    step(99);
    failed = 4'b0010;
    step(1);
    failed = '0;
    n_tests++; if (result_a !== 3'd2)  begin n_fail++; $display("FAIL to_vs_fail_result: got %0d want 2", result_a); end
    n_tests++; if (fail_ch_a !== 2'd1) begin n_fail++; $display("FAIL to_vs_fail_ch: got %0d want 1", fail_ch_a); end
    n_tests++; if (cnt_a !== 32'd100)  begin n_fail++; $display("FAIL to_vs_fail_cnt: got %0d want 100", cnt_a); end
  endtask

  task automatic test_saturate();
    do_reset();
    start_run();
    step(300);
    n_tests++; if (cnt_b !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", cnt_b); end
    n_tests++; if (done_b !== 1'b0)  begin n_fail++; $display("FAIL sat_done: got %b want 0", done_b); end
  endtask

  task automatic test_heartbeat();
    int  exp_cnt;
    logic exp_tick;
    do_reset();
    start_run();
    exp_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      en = !(c >= 6 && c <= 9);
      step(1);
      exp_tick = 1'b0;
      if (en) begin
        exp_cnt++;
        exp_tick = (exp_cnt % 4 == 0);
      end
      n_tests++; if (tick_a !== exp_tick) begin n_fail++; $display("FAIL hb_tick c=%0d: got %b want %b", c, tick_a, exp_tick); end
      n_tests++; if (cnt_a !== 32'(exp_cnt)) begin n_fail++; $display("FAIL hb_cnt c=%0d: got %0d want %0d", c, cnt_a, exp_cnt); end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_after_done();
    do_reset();
    max_a = 32'd10;
    start_run();
    step(10);
    n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL rd_done: got %b want 1", done_a); end
    step(2);
    rst = 1'b1; passed = 4'hF;
    step(1);
    n_tests++; if (done_a !== 1'b0)     begin n_fail++; $display("FAIL rd_clr_done: got %b want 0", done_a); end
    n_tests++; if (result_a !== 3'd0)   begin n_fail++; $display("FAIL rd_clr_result: got %0d want 0", result_a); end
    n_tests++; if (exitval_a !== 32'd0) begin n_fail++; $display("FAIL rd_clr_exit: got %h want 0", exitval_a); end
    n_tests++; if (ch_done_a !== 4'h0)  begin n_fail++; $display("FAIL rd_clr_ch_done: got %b want 0000", ch_done_a); end
    n_tests++; if (cnt_a !== 32'd0)     begin n_fail++; $display("FAIL rd_clr_cnt: got %0d want 0", cnt_a); end
    rst = 1'b0; passed = '0; max_a = '0;
    step(1);
    passed = 4'hF;
    step(1);
    passed = '0;
    n_tests++; if (result_a !== 3'd1)  begin n_fail++; $display("FAIL rd_rerun_result: got %0d want 1", result_a); end
    n_tests++; if (ch_done_a !== 4'hF) begin n_fail++; $display("FAIL rd_rerun_ch_done: got %b want 1111", ch_done_a); end
    n_tests++; if (cnt_a !== 32'd1)    begin n_fail++; $display("FAIL rd_rerun_cnt: got %0d want 1", cnt_a); end
  endtask

  initial begin
    test_reset();
    test_wait_all_pass();
    test_wait_all_exit();
    test_first_event();
    test_timeout();
    test_saturate();
    test_heartbeat();
    test_reset_after_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
